control_unit_fft_iter_pipe: RTL and testbench
=============================================

Name: control_unit_fft_iter_pipe

Overview:
Parametrised sequencer for the iterative in-place FFT datapath: steps through LAYERS x BUTTERFLYES butterfly operations, each a read/wait/strobe/write cycle, with a configurable RAM read latency. It drives RAM read/write enables, the address generator and the butterfly strobe. Over the 4-cycle fixed-latency sequencer it adds:
- non-power-of-two butterfly counts
- EN stall without repeated strobes
- ABORT
- a DONE pulse
- index outputs
- a latched inverse-transform mode flag

Parameters:
LAYERS, 5, number of FFT layers (>=1)
BUTTERFLYES, 16, butterflies per layer (>=1, any value)
LayWL, 3, layer index width; must satisfy 2^LayWL > LAYERS-1
ButtWL, 4, butterfly index width; must satisfy 2^ButtWL > BUTTERFLYES-1
RD_LAT, 2, cycles from RAM_EN_R to data valid at butterfly inputs (>=1)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous reset, active-low
EN  in  1  global advance enable; low = stall
START  in  1  start request, sampled in IDLE only
ABORT  in  1  terminate current transform
INV  in  1  inverse-transform request, latched with START
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse at normal completion
BUT_STROB  out  1  butterfly compute strobe
LAY_EN  out  1  layer-advance pulse to address generator
ADDR_EN  out  1  address generator step
ADDR_RST  out  1  address generator reset
RAM_EN_R  out  1  RAM read enable
RAM_EN_WR  out  1  RAM write-port enable
Wr  out  1  RAM write strobe
LAST_LAY  out  1  current layer is LAYERS-1
INV_MODE  out  1  latched INV
BUT_IDX  out  ButtWL  current butterfly index
LAY_IDX  out  LayWL  current layer index

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE; BUT_IDX=0, LAY_IDX=0, delay counter=0, INV_MODE=0.
  - All outputs 0 except ADDR_RST=1.
- States: IDLE, READ, WAIT, STROB, WRITE, DONE.
- Transitions (taken only on edges where EN=1, except ABORT):
  - IDLE: START=1 -> READ; latch INV into INV_MODE; clear indices.
  - READ -> WAIT if RD_LAT>1, else -> STROB.
  - WAIT: stays RD_LAT-1 cycles (delay counter), then -> STROB.
  - STROB -> WRITE.
  - WRITE: if BUT_IDX=BUTTERFLYES-1 and LAY_IDX=LAYERS-1 -> DONE; otherwise -> READ.
  - DONE -> IDLE.
- Index update, on WRITE exit:
  - BUT_IDX increments and wraps to 0 after BUTTERFLYES-1.
  - On wrap, LAY_IDX increments.
  - Indices never exceed their limits.
- Decoded outputs, each gated by EN so a stall never repeats a strobe:
  - RAM_EN_R = READ.
  - BUT_STROB = STROB.
  - Wr = RAM_EN_WR = ADDR_EN = WRITE.
  - LAY_EN = WRITE and BUT_IDX=BUTTERFLYES-1 and LAY_IDX!=LAYERS-1.
  - DONE = DONE state.
- Ungated outputs:
  - ADDR_RST = IDLE.
  - BUSY = state!=IDLE.
  - LAST_LAY = (state!=IDLE) and LAY_IDX=LAYERS-1.
- Timing:
  - Butterfly period = RD_LAT+2 enabled cycles.
  - Transform = LAYERS*BUTTERFLYES*(RD_LAT+2) cycles from first READ, plus 1 DONE cycle.
- EN low:
  - State, indices and delay counter hold.
  - Gated outputs 0; BUSY, LAST_LAY, indices and INV_MODE hold.
- ABORT=1 in any non-IDLE state:
  - Next edge -> IDLE regardless of EN.
  - Indices cleared; no DONE pulse.
  - ABORT in IDLE is ignored.
  - ABORT and START together in IDLE: START wins.
- START while busy is ignored. INV_MODE holds until the next accepted START.
- LAYERS=1: LAY_EN never asserted; LAST_LAY high for the whole transform.
- BUTTERFLYES=1: every WRITE is a layer wrap.
- Reset mid-transform: immediate IDLE; no DONE.

Test Plan:
1. Nominal run, LAYERS=3, BUTTERFLYES=4, RD_LAT=2, EN=1, START one cycle -> BUSY high 49 cycles; 12 RAM_EN_R, 12 BUT_STROB, 12 Wr pulses, each BUT_STROB 2 cycles after RAM_EN_R; LAY_EN 2 pulses (after butterfly 3 of layers 0 and 1); LAST_LAY high for the final 16 cycles before DONE; one DONE pulse, then IDLE with ADDR_RST=1.
2. Non-power-of-two sizes, BUTTERFLYES=5, RD_LAT=3 -> BUT_IDX sequence 0..4,0..4,0..4 with no index 5..7; butterfly period 5 cycles; 15 Wr pulses; DONE after 75+1 cycles.
3. Stall: EN low for 3 cycles in WAIT, then for 2 cycles in WRITE -> no strobes during stall, exactly one Wr for that butterfly, total cycle count extended by 5, indices unchanged during stall.
4. ABORT on the 3rd butterfly of layer 1 with EN=0 -> IDLE next edge, BUSY=0, indices 0, no DONE; a following START runs the full transform from index 0.
5. INV=1 with START, INV toggled mid-run, second START with INV=0 -> INV_MODE=1 for the whole first run, then 0 after the second START; START pulses during BUSY are ignored (BUSY length unchanged).
6. RST_N asserted asynchronously mid-WRITE -> outputs clear before the next clock edge (ADDR_RST=1, all others 0), state IDLE; RD_LAT=1, LAYERS=1 configuration -> 3-cycle butterfly period, LAY_EN never high.

Source files
------------

// File: rtl/control_unit_fft_iter_pipe.sv
// Sequencer for the iterative in-place FFT: walks LAYERS x BUTTERFLYES butterflies,
// each as READ, RD_LAT-1 WAIT cycles, STROB, WRITE; strobes are EN-gated so stalls never repeat them.
module control_unit_fft_iter_pipe #(
  parameter int LAYERS      = 5,
  parameter int BUTTERFLYES = 16,
  parameter int LayWL       = 3,
  parameter int ButtWL      = 4,
  parameter int RD_LAT      = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              START,
  input  logic              ABORT,
  input  logic              INV,
  output logic              BUSY,
  output logic              DONE,
  output logic              BUT_STROB,
  output logic              LAY_EN,
  output logic              ADDR_EN,
  output logic              ADDR_RST,
  output logic              RAM_EN_R,
  output logic              RAM_EN_WR,
  output logic              Wr,
  output logic              LAST_LAY,
  output logic              INV_MODE,
  output logic [ButtWL-1:0] BUT_IDX,
  output logic [LayWL-1:0]  LAY_IDX
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_STROB = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // WAIT counts 0..RD_LAT-2, so $clog2(RD_LAT) bits are enough
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0]     WAIT_LAST = (RD_LAT > 1) ? CW'(RD_LAT - 2) : '0;
  localparam logic [ButtWL-1:0] BUT_LAST  = ButtWL'(BUTTERFLYES - 1);
  localparam logic [LayWL-1:0]  LAY_LAST  = LayWL'(LAYERS - 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          last_but, last_lay;

  assign last_but = (BUT_IDX == BUT_LAST);
  assign last_lay = (LAY_IDX == LAY_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      cnt      <= '0;
      BUT_IDX  <= '0;
      LAY_IDX  <= '0;
      INV_MODE <= 1'b0;
    end else if (ABORT && state != S_IDLE) begin
      state   <= S_IDLE;
      cnt     <= '0;
      BUT_IDX <= '0;
      LAY_IDX <= '0;
    end else if (EN) begin
      case (state)
        S_IDLE: if (START) begin
          state    <= S_READ;
          INV_MODE <= INV;
          cnt      <= '0;
          BUT_IDX  <= '0;
          LAY_IDX  <= '0;
        end
        S_READ: begin
          cnt   <= '0;
          state <= (RD_LAT > 1) ? S_WAIT : S_STROB;
        end
        S_WAIT: begin
          if (cnt == WAIT_LAST) state <= S_STROB;
          else cnt <= cnt + CW'(1);
        end
        S_STROB: state <= S_WRITE;
        S_WRITE: begin
          // final butterfly keeps its indices through DONE
          if (last_but && last_lay) state <= S_DONE;
          else begin
            state <= S_READ;
            if (last_but) begin
              BUT_IDX <= '0;
              LAY_IDX <= LAY_IDX + LayWL'(1);
            end else begin
              BUT_IDX <= BUT_IDX + ButtWL'(1);
            end
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          BUT_IDX <= '0;
          LAY_IDX <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign RAM_EN_R  = EN && (state == S_READ);
  assign BUT_STROB = EN && (state == S_STROB);
  assign Wr        = EN && (state == S_WRITE);
  assign RAM_EN_WR = Wr;
  assign ADDR_EN   = Wr;
  assign LAY_EN    = Wr && last_but && !last_lay;
  assign DONE      = EN && (state == S_DONE);
  assign ADDR_RST  = (state == S_IDLE);
  assign BUSY      = (state != S_IDLE);
  assign LAST_LAY  = BUSY && last_lay;

endmodule

// File: tb/tb_control_unit_fft_iter_pipe.sv
// Bench for the FFT sequencer: two configurations share stimulus, each checked every cycle
// against a phase/butterfly-number model, plus a constant table and targeted corner sequences.
module tb_control_unit_fft_iter_pipe;

  localparam int LA = 3, BA = 5, RA = 3;
  localparam int LB = 1, BB = 3, RB = 1;

  typedef struct packed {
    logic busy, done, strob, lay_en, addr_en, addr_rst, ram_r, ram_wr, wr, last_lay, inv_mode;
    logic [7:0] but;
    logic [7:0] lay;
  } outs_t;

  typedef struct packed {
    logic busy;
    logic done_st;
    int   n;
    int   ph;
    logic inv;
  } mst_t;

  typedef struct {
    logic  en, start, abort, inv;
    outs_t exp;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, start = 1'b0, abort = 1'b0, inv = 1'b0;

  logic busy_a, done_a, strob_a, lay_en_a, addr_en_a, addr_rst_a, ram_r_a, ram_wr_a, wr_a, last_a, invm_a;
  logic [2:0] but_a;
  logic [1:0] lay_a;
  logic busy_b, done_b, strob_b, lay_en_b, addr_en_b, addr_rst_b, ram_r_b, ram_wr_b, wr_b, last_b, invm_b;
  logic [1:0] but_b;
  logic [0:0] lay_b;

  always #5 clk = ~clk;

  control_unit_fft_iter_pipe #(.LAYERS(LA), .BUTTERFLYES(BA), .LayWL(2), .ButtWL(3), .RD_LAT(RA)) dut_a (
    .CLK(clk), .RST_N(rst_n), .EN(en), .START(start), .ABORT(abort), .INV(inv),
    .BUSY(busy_a), .DONE(done_a), .BUT_STROB(strob_a), .LAY_EN(lay_en_a), .ADDR_EN(addr_en_a),
    .ADDR_RST(addr_rst_a), .RAM_EN_R(ram_r_a), .RAM_EN_WR(ram_wr_a), .Wr(wr_a), .LAST_LAY(last_a),
    .INV_MODE(invm_a), .BUT_IDX(but_a), .LAY_IDX(lay_a));

  control_unit_fft_iter_pipe #(.LAYERS(LB), .BUTTERFLYES(BB), .LayWL(1), .ButtWL(2), .RD_LAT(RB)) dut_b (
    .CLK(clk), .RST_N(rst_n), .EN(en), .START(start), .ABORT(abort), .INV(inv),
    .BUSY(busy_b), .DONE(done_b), .BUT_STROB(strob_b), .LAY_EN(lay_en_b), .ADDR_EN(addr_en_b),
    .ADDR_RST(addr_rst_b), .RAM_EN_R(ram_r_b), .RAM_EN_WR(ram_wr_b), .Wr(wr_b), .LAST_LAY(last_b),
    .INV_MODE(invm_b), .BUT_IDX(but_b), .LAY_IDX(lay_b));

  mst_t ma, mb;
  int nvec = 0, nfail = 0;
  int cyc_cnt, busy_cnt, wr_cnt, strob_cnt, lay_en_cnt, first_rd, first_st;

  // Model: n = global butterfly number, ph = cycle within the butterfly
  // (0 read, 1..RD-1 wait, RD strobe, RD+1 write).
  function automatic outs_t expect_o(mst_t s, int L, int B, int RD, logic e);
    outs_t o;
    int bi, li;
    logic act, w;
    bi = s.n % B;
    li = s.n / B;
    act = s.busy && !s.done_st;
    w = e && act && s.ph == RD + 1;
    o = '0;
    o.busy = s.busy;
    o.addr_rst = !s.busy;
    o.ram_r = e && act && s.ph == 0;
    o.strob = e && act && s.ph == RD;
    o.wr = w;
    o.ram_wr = w;
    o.addr_en = w;
    o.lay_en = w && bi == B - 1 && li != L - 1;
    o.done = e && s.done_st;
    o.last_lay = s.busy && li == L - 1;
    o.inv_mode = s.inv;
    o.but = 8'(bi);
    o.lay = 8'(li);
    return o;
  endfunction

  function automatic mst_t step(mst_t s, int L, int B, int RD, logic e, logic st, logic ab, logic iv);
    mst_t r;
    r = s;
    if (s.busy && ab) begin
      r.busy = 0; r.done_st = 0; r.n = 0; r.ph = 0;
    end else if (e) begin
      if (!s.busy) begin
        if (st) begin r.busy = 1; r.n = 0; r.ph = 0; r.inv = iv; end
      end else if (s.done_st) begin
        r.busy = 0; r.done_st = 0; r.n = 0;
      end else if (s.ph == RD + 1) begin
        if (s.n == L * B - 1) r.done_st = 1;
        else begin r.n = s.n + 1; r.ph = 0; end
      end else r.ph = s.ph + 1;
    end
    return r;
  endfunction

  function automatic outs_t got_a();
    outs_t o;
    o = '{busy_a, done_a, strob_a, lay_en_a, addr_en_a, addr_rst_a, ram_r_a, ram_wr_a, wr_a, last_a, invm_a,
          8'(but_a), 8'(lay_a)};
    return o;
  endfunction

  function automatic outs_t got_b();
    outs_t o;
    o = '{busy_b, done_b, strob_b, lay_en_b, addr_en_b, addr_rst_b, ram_r_b, ram_wr_b, wr_b, last_b, invm_b,
          8'(but_b), 8'(lay_b)};
    return o;
  endfunction

  task automatic chk(input string nm, input outs_t got, input outs_t exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s @%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic clr();
    cyc_cnt = 0; busy_cnt = 0; wr_cnt = 0; strob_cnt = 0; lay_en_cnt = 0; first_rd = -1; first_st = -1;
  endtask

  // Called just after a rising edge: drive, check on the falling edge, advance models on the rising edge.
  task automatic cyc(input logic e, s, a, i, input bit use_t, input outs_t texp);
    en = e; start = s; abort = a; inv = i;
    @(negedge clk);
    chk("dut_a", got_a(), expect_o(ma, LA, BA, RA, e));
    chk("dut_b", got_b(), expect_o(mb, LB, BB, RB, e));
    if (use_t) chk("table_b", got_b(), texp);
    if (busy_a) busy_cnt++;
    if (wr_a) wr_cnt++;
    if (strob_a) strob_cnt++;
    if (lay_en_a) lay_en_cnt++;
    if (ram_r_a && first_rd < 0) first_rd = cyc_cnt;
    if (strob_a && first_st < 0) first_st = cyc_cnt;
    cyc_cnt++;
    @(posedge clk);
    if (!rst_n) begin
      ma = '0; mb = '0;
    end else begin
      ma = step(ma, LA, BA, RA, e, s, a, i);
      mb = step(mb, LB, BB, RB, e, s, a, i);
    end
    #1;
  endtask

  task automatic run(input logic e, s, a, i);
    cyc(e, s, a, i, 1'b0, '0);
  endtask

  function automatic vec_t mk(logic e, s, i, b, d, st, rd, w, ll, ar, im, int bi);
    vec_t v;
    v.en = e; v.start = s; v.abort = 1'b0; v.inv = i;
    v.exp = '0;
    v.exp.busy = b; v.exp.done = d; v.exp.strob = st; v.exp.ram_r = rd;
    v.exp.wr = w; v.exp.ram_wr = w; v.exp.addr_en = w;
    v.exp.last_lay = ll; v.exp.addr_rst = ar; v.exp.inv_mode = im;
    v.exp.but = 8'(bi);
    return v;
  endfunction

  initial begin
    vec_t tbl[13];
    bit s1, s2;
    int k;
    // Hand-derived run of dut_b (1 layer, 3 butterflies, RD_LAT=1 -> 3-cycle period)
    tbl[0]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0);
    tbl[2]  = mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0);
    tbl[3]  = mk(1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0);
    tbl[4]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1);
    tbl[5]  = mk(1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 1);
    tbl[6]  = mk(1, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1);
    tbl[7]  = mk(1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 1);
    tbl[8]  = mk(1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 2);
    tbl[9]  = mk(1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 2);
    tbl[10] = mk(1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 2);
    tbl[11] = mk(1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 2);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

    ma = '0; mb = '0;
    clr();
    @(posedge clk); #1;
    run(1, 1, 0, 1);
    run(1, 0, 0, 0);
    rst_n = 1'b1;

    for (int t = 0; t < 13; t++)
      cyc(tbl[t].en, tbl[t].start, tbl[t].abort, tbl[t].inv, 1'b1, tbl[t].exp);

    // drain dut_a's run
    k = 0;
    while (ma.busy && k < 200) begin run(1, 0, 0, 0); k++; end
    chk_i("drain_bound", k < 200, 1);

    // nominal uninterrupted run: 15 butterflies x 5 cycles + DONE
    clr();
    run(1, 1, 0, 0);
    for (int t = 0; t < 80; t++) run(1, 0, 0, 0);
    chk_i("busy_len", busy_cnt, 76);
    chk_i("wr_count", wr_cnt, 15);
    chk_i("strob_count", strob_cnt, 15);
    chk_i("lay_en_count", lay_en_cnt, 2);
    chk_i("rd_to_strob", first_st - first_rd, RA);

    // stall 3 cycles in WAIT and 2 in WRITE of the first butterfly
    clr();
    s1 = 0; s2 = 0;
    run(1, 1, 0, 0);
    while (cyc_cnt < 90) begin
      if (!s1 && ma.busy && ma.ph == 1) begin
        repeat (3) run(0, 0, 0, 0);
        s1 = 1;
      end else if (s1 && !s2 && ma.ph == RA + 1) begin
        repeat (2) run(0, 0, 0, 0);
        s2 = 1;
      end else run(1, 0, 0, 0);
    end
    chk_i("stall_busy_len", busy_cnt, 81);
    chk_i("stall_wr_count", wr_cnt, 15);

    // abort with EN low on the 3rd butterfly of layer 1, then a full rerun
    run(1, 1, 0, 1);
    k = 0;
    while (!(ma.n == BA + 2 && ma.ph == 2) && k < 200) begin run(1, 0, 0, 0); k++; end
    chk_i("abort_reach", k < 200, 1);
    run(0, 0, 1, 0);
    chk_i("abort_busy", busy_a, 0);
    chk_i("abort_but", int'(but_a), 0);
    chk_i("abort_lay", int'(lay_a), 0);
    clr();
    run(1, 1, 0, 0);
    for (int t = 0; t < 80; t++) run(1, 0, 0, 0);
    chk_i("rerun_busy_len", busy_cnt, 76);

    // randomized traffic against the model
    for (int t = 0; t < 800; t++)
      run(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 40) == 0, 1'($urandom % 2));

    // asynchronous reset while dut_a is in WRITE
    k = 0;
    run(1, 1, 0, 1);
    while (!(ma.busy && !ma.done_st && ma.ph == RA + 1) && k < 200) begin run(1, 0, 0, 0); k++; end
    chk_i("write_reach", k < 200, 1);
    rst_n = 1'b0;
    #1;
    ma = '0; mb = '0;
    chk("async_rst_a", got_a(), expect_o(ma, LA, BA, RA, en));
    chk("async_rst_b", got_b(), expect_o(mb, LB, BB, RB, en));
    #1 rst_n = 1'b1;
    for (int t = 0; t < 4; t++) run(1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
